// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding.
// Used by uart_rx_core and its interface; the transmitter shares UART_DATA_BITS.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_BCNT_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver-to-consumer bus.
//   RxD_data      : last correctly framed byte
//   RxD_ready     : one-cycle strobe, RxD_data updated
//   RxD_frame_err : one-cycle strobe, stop bit sampled low
//   Busy          : receiver not idle
// master = receiver (drives), slave = consumer (observes).
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] RxD_data;
  logic                      RxD_ready;
  logic                      RxD_frame_err;
  logic                      Busy;

  modport master (output RxD_data, output RxD_ready, output RxD_frame_err, output Busy);
  modport slave  (input  RxD_data, input  RxD_ready, input  RxD_frame_err, input  Busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk, rst : clock, async active-high reset (both flops load RESET_VAL)
//   d        : asynchronous input
//   q        : synchronized output, 2 clk latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with oversampled start-bit validation.
//   clk, rst       : clock, async active-high reset
//   RxD            : serial line, asynchronous, idle high
//   OversampleTick : one-clk pulse at OVERSAMPLE x baud
//   rx (master)    : RxD_data / RxD_ready / RxD_frame_err / Busy
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RxD,
  input  logic           OversampleTick,
  uart_rx_core_if.master rx
);

  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam logic [TCNT_W-1:0]      HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0]      FULL_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [UART_BCNT_W-1:0] BIT_LAST  = UART_BCNT_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_rx_state_e            state, state_next;
  logic [TCNT_W-1:0]         tcnt, tcnt_next;
  logic [UART_BCNT_W-1:0]    bcnt, bcnt_next;
  logic [UART_DATA_BITS-1:0] sh, sh_next;
  logic [UART_DATA_BITS-1:0] data_q, data_next;
  logic                      ready_q, ready_next;
  logic                      ferr_q, ferr_next;
  logic                      busy_q, busy_next;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxs)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      sh      <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      tcnt    <= tcnt_next;
      bcnt    <= bcnt_next;
      sh      <= sh_next;
      data_q  <= data_next;
      ready_q <= ready_next;
      ferr_q  <= ferr_next;
      busy_q  <= busy_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    bcnt_next  = bcnt;
    sh_next    = sh;
    data_next  = data_q;
    ready_next = 1'b0;
    ferr_next  = 1'b0;

    unique case (state)
      // Ticks are ignored here, so a tick coincident with the falling edge
      // never counts toward the half-bit wait.
      IDLE: begin
        tcnt_next = '0;
        bcnt_next = '0;
        if (!rxs) state_next = START;
      end

      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (OversampleTick) begin
          if (tcnt == HALF_LAST) begin
            tcnt_next  = '0;
            bcnt_next  = '0;
            state_next = rxs ? IDLE : DATA;
          end else begin
            tcnt_next = tcnt + TCNT_W'(1);
          end
        end
      end

      DATA: begin
        if (OversampleTick) begin
          if (tcnt == FULL_LAST) begin
            tcnt_next = '0;
            sh_next   = {rxs, sh[UART_DATA_BITS-1:1]};
            bcnt_next = bcnt + UART_BCNT_W'(1);
            if (bcnt == BIT_LAST) state_next = STOP;
          end else begin
            tcnt_next = tcnt + TCNT_W'(1);
          end
        end
      end

      // Leaving at mid stop bit lets IDLE catch a back-to-back start edge.
      STOP: begin
        if (OversampleTick) begin
          if (tcnt == FULL_LAST) begin
            tcnt_next = '0;
            if (rxs) begin
              data_next  = sh;
              ready_next = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = WAIT_HIGH;
            end
          end else begin
            tcnt_next = tcnt + TCNT_W'(1);
          end
        end
      end

      // Break or stuck-low line: hold off until it returns high.
      WAIT_HIGH: begin
        if (rxs) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign rx.RxD_data      = data_q;
  assign rx.RxD_ready     = ready_q;
  assign rx.RxD_frame_err = ferr_q;
  assign rx.Busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected strobes,
// a negedge monitor pops and compares them.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic rst;
  logic RxD;
  logic OversampleTick;

  uart_rx_core_if rx_if ();

  uart_rx_core #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD            (RxD),
    .OversampleTick (OversampleTick),
    .rx             (rx_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_good;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Tick every 4 clk with a random phase.
  initial begin
    int c;
    c = int'($urandom_range(0, 3));
    OversampleTick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      OversampleTick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  // Reference model: a good stop bit delivers the byte; a bad one repeats the last good byte.
  function automatic void expect_frame(input logic [7:0] data, input bit stop_ok);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? data : last_good;
    if (stop_ok) last_good = data;
    q.push_back(e);
  endfunction

  task automatic drive_for(input logic b, input int n);
    RxD = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int per);
    expect_frame(data, stop_ok);
    drive_for(1'b0, per);
    for (int i = 0; i < 8; i++) drive_for(data[i], per);
    drive_for(stop_ok, per);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (rx_if.Busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(rx_if.Busy), 32'd0);
  endtask

  // Monitor: every strobe must match the next expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_if.RxD_ready || rx_if.RxD_frame_err)) begin
      if (rx_if.RxD_ready && rx_if.RxD_frame_err) check("strobe_exclusive", 32'd1, 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: actual ready=%0b err=%0b data=%0h required no strobe",
                 rx_if.RxD_ready, rx_if.RxD_frame_err, rx_if.RxD_data);
      end else begin
        e = q.pop_front();
        check("strobe_kind_err", 32'(rx_if.RxD_frame_err), 32'(e.is_err));
        check("strobe_data", 32'(rx_if.RxD_data), 32'(e.data));
      end
    end
  end

  // Global watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c3;
    rst       = 1'b1;
    RxD       = 1'b1;
    last_good = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(rx_if.RxD_data), 32'h00);
    check("rst_ready", 32'(rx_if.RxD_ready), 32'd0);
    check("rst_ferr", 32'(rx_if.RxD_frame_err), 32'd0);
    check("rst_busy", 32'(rx_if.Busy), 32'd0);
    rst = 1'b0;
    drive_for(1'b1, 40);

    // Single frame A5, with Busy latency checked on the start edge.
    expect_frame(8'hA5, 1'b1);
    RxD = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_edge3", 32'(rx_if.Busy), 32'd0);
    @(posedge clk);
    #1;
    check("busy_at_edge3", 32'(rx_if.Busy), 32'd1);
    drive_for(1'b0, BIT_CLK - 3);
    for (int i = 0; i < 8; i++) drive_for(1'(8'hA5 >> i), BIT_CLK);
    drive_for(1'b1, BIT_CLK);
    drive_for(1'b1, 30);

    // Back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, BIT_CLK);
    send_frame(8'hFF, 1'b1, BIT_CLK);
    send_frame(8'h55, 1'b1, BIT_CLK);
    drive_for(1'b1, 20);
    check("b2b_drained", 32'(q.size()), 32'd0);

    // Glitch: low 5 ticks then high.
    drive_for(1'b0, 20);
    drive_for(1'b1, 4);
    wait_idle("glitch_busy_idle");
    drive_for(1'b1, 16);
    send_frame(8'h3C, 1'b1, BIT_CLK);
    drive_for(1'b1, 20);

    // Framing error, line then held low.
    send_frame(8'h81, 1'b0, BIT_CLK);
    drive_for(1'b0, 120);
    check("ferr_seen", 32'(q.size()), 32'd0);
    check("ferr_busy_low_line", 32'(rx_if.Busy), 32'd1);
    check("ferr_data_kept", 32'(rx_if.RxD_data), 32'h3C);
    RxD = 1'b1;
    wait_idle("ferr_busy_release");
    drive_for(1'b1, 20);
    send_frame(8'h7E, 1'b1, BIT_CLK);
    drive_for(1'b1, 20);

    // Randomized frames with small baud mismatch and random gaps.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      int per, gap;
      d   = 8'($urandom);
      per = 63 + int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 40));
      send_frame(d, 1'b1, per);
      if (gap > 0) drive_for(1'b1, gap);
    end
    drive_for(1'b1, 20);
    check("random_drained", 32'(q.size()), 32'd0);

    // Abort: reset during bit 4 of C3.
    c3 = 8'hC3;
    drive_for(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_for(c3[i], BIT_CLK);
    drive_for(c3[4], 20);
    rst = 1'b1;
    #2;
    check("abort_ready", 32'(rx_if.RxD_ready), 32'd0);
    check("abort_ferr", 32'(rx_if.RxD_frame_err), 32'd0);
    check("abort_data", 32'(rx_if.RxD_data), 32'h00);
    check("abort_busy", 32'(rx_if.Busy), 32'd0);
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    last_good = 8'h00;
    drive_for(1'b1, 10);
    send_frame(8'h18, 1'b1, BIT_CLK);
    drive_for(1'b1, 20);
    check("final_data", 32'(rx_if.RxD_data), 32'h18);
    check("final_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
